// File: rtl/envelope_generator.sv
// ADSR-style envelope generator.
// A key-press trigger restarts ATTACK from the current level. The envelope
// then steps on a divided tick through DECAY to SUSTAIN. Releasing the gate
// enters RELEASE, which ramps the level down to zero and returns to IDLE.
module envelope_generator #(
    parameter int unsigned ENV_WIDTH     = 16,
    parameter int unsigned TICK_DIV      = 1024,
    parameter int unsigned ATTACK_STEP   = 16'h0040,
    parameter int unsigned DECAY_STEP    = 16'h0010,
    parameter int unsigned SUSTAIN_LEVEL = 16'hC000,
    parameter int unsigned RELEASE_STEP  = 16'h0020
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 gate_in,
    input  logic                 trigger_in,
    input  logic [2:0]           note_sel_in,
    input  logic                 note_valid_in,
    output logic [ENV_WIDTH-1:0] env_out,
    output logic [2:0]           note_out,
    output logic [2:0]           state_out,
    output logic                 active_out
);

    localparam int unsigned          CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ENV_WIDTH-1:0] ENV_MAX  = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] ENV_ZERO = {ENV_WIDTH{1'b0}};
    localparam logic [ENV_WIDTH-1:0] ATK_C    = ENV_WIDTH'(ATTACK_STEP);
    localparam logic [ENV_WIDTH-1:0] DCY_C    = ENV_WIDTH'(DECAY_STEP);
    localparam logic [ENV_WIDTH-1:0] SUS_C    = ENV_WIDTH'(SUSTAIN_LEVEL);
    localparam logic [ENV_WIDTH-1:0] REL_C    = ENV_WIDTH'(RELEASE_STEP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q,   env_d;
    logic [2:0]           note_q,  note_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 active_q, active_d;

    logic                 tick_s;
    logic                 accept_s;
    logic                 gate_drop_s;
    logic [ENV_WIDTH:0]   atk_sum_s;

    // Event decode: divided tick, accepted trigger, gate released while sounding.
    always_comb begin
        tick_s      = (cnt_q == CNT_LAST);
        accept_s    = trigger_in & gate_in & note_valid_in;
        gate_drop_s = ~gate_in & ((state_q == ST_ATTACK) ||
                                  (state_q == ST_DECAY)  ||
                                  (state_q == ST_SUSTAIN));
        // One extra bit so the attack sum can be saturated without wrapping.
        atk_sum_s   = {1'b0, env_q} + {1'b0, ATK_C};
    end

    // Tick divider: free-running wrap, restarted by an accepted trigger so the
    // first attack step lands a full tick period after the key press.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and envelope arithmetic: trigger beats gate-drop beats tick.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        note_d  = note_q;
        if (accept_s) begin
            // A retrigger keeps the current level so there is no audible click.
            state_d = ST_ATTACK;
            note_d  = note_sel_in;
        end else if (gate_drop_s) begin
            state_d = ST_RELEASE;
        end else if (tick_s) begin
            case (state_q)
                ST_ATTACK: begin
                    if (atk_sum_s >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = atk_sum_s[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    // Compare the remaining gap rather than subtracting first,
                    // so the step can never underflow below the sustain level.
                    if (env_q <= SUS_C) begin
                        env_d   = SUS_C;
                        state_d = ST_SUSTAIN;
                    end else if ((env_q - SUS_C) <= DCY_C) begin
                        env_d   = SUS_C;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_q - DCY_C;
                    end
                end
                ST_SUSTAIN: begin
                    env_d = SUS_C;
                end
                ST_RELEASE: begin
                    if (env_q <= REL_C) begin
                        env_d   = ENV_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - REL_C;
                    end
                end
                ST_IDLE: begin
                    env_d = ENV_ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    env_d   = ENV_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        active_d = (state_d != ST_IDLE);
    end

    // State, envelope, note and tick registers with asynchronous abort to idle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            env_q    <= ENV_ZERO;
            note_q   <= 3'd0;
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            note_q   <= note_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign env_out    = env_q;
    assign note_out   = note_q;
    assign state_out  = state_q;
    assign active_out = active_q;

endmodule

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 SHALL have parameter ENV_WIDTH, default 16, envelope amplitude width in bits.
REQ-002 SHALL have parameter TICK_DIV, default 1024, clock cycles per envelope step (legal range >= 2).
REQ-003 SHALL have parameter ATTACK_STEP, default 16'h0040, amount added per tick in ATTACK.
REQ-004 SHALL have parameter DECAY_STEP, default 16'h0010, amount subtracted per tick in DECAY.
REQ-005 SHALL have parameter SUSTAIN_LEVEL, default 16'hC000, hold level in SUSTAIN.
REQ-006 SHALL have parameter RELEASE_STEP, default 16'h0020, amount subtracted per tick in RELEASE.
REQ-007 SHALL have the port clk_in, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-008 SHALL have the port rst_in, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have the port gate_in, input, 1 bit, key-held level from the note decoder.
REQ-010 SHALL have the port trigger_in, input, 1 bit, single-cycle key-press pulse from the note decoder.
REQ-011 SHALL have the port note_sel_in, input, 3 bits, selected note index.
REQ-012 SHALL have the port note_valid_in, input, 1 bit, high when note_sel_in is a legal selection.
REQ-013 SHALL have the port env_out, output, ENV_WIDTH bits, current envelope amplitude (unsigned).
REQ-014 SHALL have the port note_out, output, 3 bits, note latched at the last accepted trigger.
REQ-015 SHALL have the port state_out, output, 3 bits, encoding IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-016 SHALL have the port active_out, output, 1 bit, high whenever state_out != IDLE.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be a one-cycle internal pulse when count == TICK_DIV-1.
REQ-018 Trigger SHALL be accepted only when trigger_in, gate_in and note_valid_in are all high in the same cycle; otherwise it is ignored.
REQ-019 Accepted trigger, from any state (including ATTACK itself), SHALL do three things on the next edge: state <= ATTACK, note_out <= note_sel_in, tick counter <= 0; env_out is NOT reset (retrigger continues from the current level).
REQ-020 ATTACK: on each tick, env SHALL become min(env + ATTACK_STEP, 2^ENV_WIDTH-1), computed at ENV_WIDTH+1 bits; on the edge where it reaches max, state SHALL become DECAY.
REQ-021 DECAY: on each tick, env SHALL become max(env - DECAY_STEP, SUSTAIN_LEVEL) without underflow; on the edge where it reaches SUSTAIN_LEVEL, state SHALL become SUSTAIN.
REQ-022 SUSTAIN: env SHALL hold at SUSTAIN_LEVEL while gate_in stays high.
REQ-023 If gate_in is low in ATTACK, DECAY or SUSTAIN, state SHALL become RELEASE on the next edge, regardless of tick; env holds its value on that edge.
REQ-024 RELEASE: on each tick, env SHALL become max(env - RELEASE_STEP, 0); on the edge where it reaches 0, state SHALL become IDLE.
REQ-025 IDLE: env SHALL be 0 and hold; ticks have no effect.
REQ-026 Priority per cycle SHALL be: accepted trigger > gate-low release > tick step.
REQ-027 Trigger_in while gate_in is low SHALL be ignored (gate low wins).
REQ-028 note_out SHALL hold through RELEASE and IDLE until the next accepted trigger.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 While rst_in is low, asynchronously: env_out=0, note_out=0, state_out=IDLE, active_out=0, tick counter=0.
REQ-031 Reset asserted mid-envelope SHALL abort immediately to the reset values; after release, the block SHALL stay in IDLE until a new accepted trigger.

Verification (TICK_DIV=4, ATTACK_STEP=16'h4000, DECAY_STEP=16'h1000, SUSTAIN_LEVEL=16'h8000, RELEASE_STEP=16'h2000)
REQ-032 Full cycle: trigger with note 5, gate held -> env 4000, 8000, C000, FFFF at ticks 1-4 (every 4 cycles), DECAY to 8000 after 8 more ticks, SUSTAIN; gate low -> RELEASE 6000, 4000, 2000, 0 -> IDLE; note_out=5 throughout.
REQ-033 Early release: gate low after 2 attack ticks (env 8000) -> RELEASE next edge, env 6000, 4000, 2000, 0 on following ticks.
REQ-034 Retrigger: trigger with note 3 during RELEASE at env 4000 -> ATTACK, note_out=3, next tick env 8000.
REQ-035 Rejects: trigger with note_valid_in=0, or with gate_in=0 -> state, env and note_out unchanged.
REQ-036 Reset: rst_in low during DECAY at env C000 -> all outputs zero/IDLE immediately, no clock edge needed; no activity after reset deasserts.
